hh_neuron_scheduler: RTL

//  Time-multiplexes one shared Hodgkin-Huxley update engine across N_NEURONS neurons.

---
 rtl/hh_neuron_scheduler_pkg.sv | 22 ++
 rtl/hh_neuron_scheduler_if.sv | 40 ++++
 rtl/hh_neuron_scheduler_regfile.sv | 82 ++++++++
 rtl/hh_neuron_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hh_neuron_scheduler_pkg.sv
// Shared definitions for the Hodgkin-Huxley neuron scheduler: FSM encoding,
// per-neuron reset constants and the default engine timeout.
package hh_neuron_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_OUTPUT
  } state_e;

  // Resting membrane potential of -65 stored as 16-bit two's complement (16'hFFBF).
  localparam logic signed [15:0] V_REST = -16'sd65;
  localparam logic [15:0]        M0     = 16'd0;
  localparam logic [15:0]        H0     = 16'd1;
  localparam logic [15:0]        N0     = 16'd0;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int WAIT_CNT_W      = 8;

endpackage

// File: rtl/hh_neuron_scheduler_if.sv
// Engine operand/result handshake plus the V-sample valid/ready stream.
// The master side is the scheduler; the slave side is the engine and sample consumer.
interface hh_neuron_scheduler_if #(
  parameter int DW    = 16,
  parameter int IDX_W = 2
) ();

  logic             eng_start;
  logic [DW-1:0]    eng_v;
  logic [DW-1:0]    eng_m;
  logic [DW-1:0]    eng_h;
  logic [DW-1:0]    eng_n;
  logic [DW-1:0]    eng_i;
  logic [DW-1:0]    eng_dt;
  logic             eng_done;
  logic [DW-1:0]    eng_v_next;
  logic [DW-1:0]    eng_m_next;
  logic [DW-1:0]    eng_h_next;
  logic [DW-1:0]    eng_n_next;

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [DW-1:0]    out_v;

  modport master (
    output eng_start, eng_v, eng_m, eng_h, eng_n, eng_i, eng_dt,
    input  eng_done, eng_v_next, eng_m_next, eng_h_next, eng_n_next,
    output out_valid, out_idx, out_v,
    input  out_ready
  );

  modport slave (
    input  eng_start, eng_v, eng_m, eng_h, eng_n, eng_i, eng_dt,
    output eng_done, eng_v_next, eng_m_next, eng_h_next, eng_n_next,
    input  out_valid, out_idx, out_v,
    output out_ready
  );

endinterface

// File: rtl/hh_neuron_scheduler_regfile.sv
// Per-neuron state store {V,m,h,n,I}: one combinational read port, a state write
// port used by the scheduler and an independent current write port for configuration.
module hh_state_regfile
  import hh_neuron_scheduler_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = 2,
  parameter int DW        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [DW-1:0]    rd_v,
  output logic [DW-1:0]    rd_m,
  output logic [DW-1:0]    rd_h,
  output logic [DW-1:0]    rd_n,
  output logic [DW-1:0]    rd_i,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [DW-1:0]    wr_v,
  input  logic [DW-1:0]    wr_m,
  input  logic [DW-1:0]    wr_h,
  input  logic [DW-1:0]    wr_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [DW-1:0]    cfg_current
);

  logic [DW-1:0] v_q [N_NEURONS];
  logic [DW-1:0] m_q [N_NEURONS];
  logic [DW-1:0] h_q [N_NEURONS];
  logic [DW-1:0] n_q [N_NEURONS];
  logic [DW-1:0] i_q [N_NEURONS];
  logic [DW-1:0] v_d [N_NEURONS];
  logic [DW-1:0] m_d [N_NEURONS];
  logic [DW-1:0] h_d [N_NEURONS];
  logic [DW-1:0] n_d [N_NEURONS];
  logic [DW-1:0] i_d [N_NEURONS];

  // State and current are separate fields, so a writeback and a cfg write to the same neuron both land.
  always_comb begin
    v_d = v_q;
    m_d = m_q;
    h_d = h_q;
    n_d = n_q;
    i_d = i_q;
    if (wr_en) begin
      v_d[wr_idx] = wr_v;
      m_d[wr_idx] = wr_m;
      h_d[wr_idx] = wr_h;
      n_d[wr_idx] = wr_n;
    end
    if (cfg_we && (int'(cfg_idx) < N_NEURONS)) begin
      i_d[cfg_idx] = cfg_current;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        v_q[k] <= DW'(V_REST);
        m_q[k] <= DW'(M0);
        h_q[k] <= DW'(H0);
        n_q[k] <= DW'(N0);
        i_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      m_q <= m_d;
      h_q <= h_d;
      n_q <= n_d;
      i_q <= i_d;
    end
  end

  assign rd_v = v_q[rd_idx];
  assign rd_m = m_q[rd_idx];
  assign rd_h = h_q[rd_idx];
  assign rd_n = n_q[rd_idx];
  assign rd_i = i_q[rd_idx];

endmodule

// File: rtl/hh_neuron_scheduler.sv
// Time-multiplexes one Hodgkin-Huxley update engine over N_NEURONS neurons,
// one sweep per step_tick, presenting each updated V on a valid/ready port.
module hh_neuron_scheduler
  import hh_neuron_scheduler_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = 2,
  parameter int DW        = 16,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 step_tick,
  input  logic [DW-1:0]        dt,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [DW-1:0]        cfg_current,
  hh_neuron_scheduler_if.master bus,
  output logic                 busy,
  output logic                 sweep_done,
  output logic                 overrun,
  output logic                 eng_err
);

  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(N_NEURONS - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      rd_idx;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic                  eng_err_q, eng_err_d;
  logic                  sweep_done_q, sweep_done_d;
  logic [DW-1:0]         op_v_q, op_v_d, op_m_q, op_m_d, op_h_q, op_h_d;
  logic [DW-1:0]         op_n_q, op_n_d, op_i_q, op_i_d, op_dt_q, op_dt_d;
  logic [DW-1:0]         res_v_q, res_v_d, res_m_q, res_m_d;
  logic [DW-1:0]         res_h_q, res_h_d, res_n_q, res_n_d;
  logic [DW-1:0]         out_v_q, out_v_d;
  logic [DW-1:0]         rd_v, rd_m, rd_h, rd_n, rd_i;
  logic                  wr_en;
  logic                  load_ops;

  // Operands are only ever loaded on entry to ISSUE: idx 0 from IDLE, idx+1 from OUTPUT.
  assign rd_idx = (state_q == ST_OUTPUT) ? idx_q + IDX_W'(1) : '0;

  hh_state_regfile #(
    .N_NEURONS (N_NEURONS),
    .IDX_W     (IDX_W),
    .DW        (DW)
  ) u_regfile (
    .clock       (clock),
    .reset_n     (reset_n),
    .rd_idx      (rd_idx),
    .rd_v        (rd_v),
    .rd_m        (rd_m),
    .rd_h        (rd_h),
    .rd_n        (rd_n),
    .rd_i        (rd_i),
    .wr_en       (wr_en),
    .wr_idx      (idx_q),
    .wr_v        (res_v_q),
    .wr_m        (res_m_q),
    .wr_h        (res_h_q),
    .wr_n        (res_n_q),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_current (cfg_current)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_cnt_d   = wait_cnt_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    eng_err_d    = eng_err_q;
    sweep_done_d = 1'b0;
    op_v_d       = op_v_q;
    op_m_d       = op_m_q;
    op_h_d       = op_h_q;
    op_n_d       = op_n_q;
    op_i_d       = op_i_q;
    op_dt_d      = op_dt_q;
    res_v_d      = res_v_q;
    res_m_d      = res_m_q;
    res_h_d      = res_h_q;
    res_n_d      = res_n_q;
    out_v_d      = out_v_q;
    wr_en        = 1'b0;
    load_ops     = 1'b0;

    if (step_tick && (state_q != ST_IDLE)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (step_tick || pending_q) begin
          state_d   = ST_ISSUE;
          idx_d     = '0;
          pending_d = step_tick && pending_q;
          load_ops  = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      // Results are only valid during the eng_done pulse, so capture them here for WRITE.
      ST_WAIT: begin
        if (bus.eng_done) begin
          res_v_d = bus.eng_v_next;
          res_m_d = bus.eng_m_next;
          res_h_d = bus.eng_h_next;
          res_n_d = bus.eng_n_next;
          out_v_d = bus.eng_v_next;
          state_d = ST_WRITE;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          eng_err_d = 1'b1;
          out_v_d   = op_v_q;
          state_d   = ST_OUTPUT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      ST_WRITE: begin
        wr_en   = 1'b1;
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            sweep_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            state_d  = ST_ISSUE;
            load_ops = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_ops) begin
      op_v_d  = rd_v;
      op_m_d  = rd_m;
      op_h_d  = rd_h;
      op_n_d  = rd_n;
      op_i_d  = rd_i;
      op_dt_d = dt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      wait_cnt_q   <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      eng_err_q    <= 1'b0;
      sweep_done_q <= 1'b0;
      op_v_q       <= '0;
      op_m_q       <= '0;
      op_h_q       <= '0;
      op_n_q       <= '0;
      op_i_q       <= '0;
      op_dt_q      <= '0;
      res_v_q      <= '0;
      res_m_q      <= '0;
      res_h_q      <= '0;
      res_n_q      <= '0;
      out_v_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wait_cnt_q   <= wait_cnt_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      eng_err_q    <= eng_err_d;
      sweep_done_q <= sweep_done_d;
      op_v_q       <= op_v_d;
      op_m_q       <= op_m_d;
      op_h_q       <= op_h_d;
      op_n_q       <= op_n_d;
      op_i_q       <= op_i_d;
      op_dt_q      <= op_dt_d;
      res_v_q      <= res_v_d;
      res_m_q      <= res_m_d;
      res_h_q      <= res_h_d;
      res_n_q      <= res_n_d;
      out_v_q      <= out_v_d;
    end
  end

  assign bus.eng_start = (state_q == ST_ISSUE);
  assign bus.eng_v     = op_v_q;
  assign bus.eng_m     = op_m_q;
  assign bus.eng_h     = op_h_q;
  assign bus.eng_n     = op_n_q;
  assign bus.eng_i     = op_i_q;
  assign bus.eng_dt    = op_dt_q;
  assign bus.out_valid = (state_q == ST_OUTPUT);
  assign bus.out_idx   = idx_q;
  assign bus.out_v     = out_v_q;

  assign busy       = (state_q != ST_IDLE);
  assign sweep_done = sweep_done_q;
  assign overrun    = overrun_q;
  assign eng_err    = eng_err_q;

endmodule
